// File: rtl/iccm_port_arbiter.sv
// Sequenced arbiter sharing the single-port instruction RAM between the core and the UART loader.
// Optional build macro ICCM_ARB_RR_EN selects round-robin core/loader arbitration in RUN.
module iccm_port_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_req_i,
    input  logic                 core_we_i,
    input  logic [AW-1:0]        core_addr_i,
    input  logic [DW-1:0]        core_wdata_i,
    input  logic [DW/8-1:0]      core_be_i,
    output logic                 core_gnt_o,
    output logic                 core_rvalid_o,
    output logic [DW-1:0]        core_rdata_o,
    input  logic                 prog_active_i,
    input  logic                 prog_we_i,
    input  logic [AW-1:0]        prog_addr_i,
    input  logic [DW-1:0]        prog_wdata_i,
    output logic                 prog_gnt_o,
    output logic [CNTW-1:0]      prog_wr_cnt_o,
    output logic                 load_mode_o,
    output logic                 ram_en_o,
    output logic [DW/8-1:0]      ram_we_o,
    output logic [AW-1:0]        ram_a_o,
    output logic [DW-1:0]        ram_di_o,
    input  logic [DW-1:0]        ram_do_i
);

    localparam int NB = DW / 8;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t          state;
    logic            active_q;
    logic            rvalid_q;
    logic [CNTW-1:0] cnt;
    logic            rise;
    logic            prog_win;
    logic            core_win;
    logic            core_gnt;
    logic            prog_gnt;
    logic            rd_fire;
`ifdef ICCM_ARB_RR_EN
    logic            last_prog;
`endif

    always_comb begin
        rise = prog_active_i & ~active_q;
`ifdef ICCM_ARB_RR_EN
        // On a collision the side that did not win the previous collision goes first.
        prog_win = prog_we_i & ~(core_req_i & last_prog);
`else
        prog_win = prog_we_i;
`endif
        core_win = core_req_i & ~prog_win;
        core_gnt = 1'b0;
        prog_gnt = 1'b0;
        case (state)
            RUN: begin
                core_gnt = core_win;
                prog_gnt = prog_win;
            end
            DRAIN, LOAD: prog_gnt = prog_we_i;
            default: ;
        endcase
        // Grants are combinational, so hold them low while reset is asserted.
        core_gnt = core_gnt & rst_ni;
        prog_gnt = prog_gnt & rst_ni;
        rd_fire  = core_gnt & ~core_we_i;
    end

    assign core_gnt_o    = core_gnt;
    assign prog_gnt_o    = prog_gnt;
    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = ram_do_i;
    assign prog_wr_cnt_o = cnt;
    assign load_mode_o   = (state == LOAD);

    assign ram_en_o = core_gnt | prog_gnt;
    assign ram_we_o = prog_gnt ? {NB{1'b1}} :
                      core_gnt ? (core_be_i & {NB{core_we_i}}) : '0;
    assign ram_a_o  = prog_gnt ? prog_addr_i  : core_addr_i;
    assign ram_di_o = prog_gnt ? prog_wdata_i : core_wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RUN;
            active_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            cnt       <= '0;
`ifdef ICCM_ARB_RR_EN
            last_prog <= 1'b1;
`endif
        end else begin
            active_q <= prog_active_i;
            rvalid_q <= rd_fire;
            if (prog_gnt && cnt != {CNTW{1'b1}})
                cnt <= cnt + 1'b1;
            case (state)
                RUN: if (rise) begin
                    // A read granted in the rising cycle still owes its rvalid.
                    state <= rd_fire ? DRAIN : LOAD;
                    cnt   <= '0;
                end
                DRAIN: state <= LOAD;
                LOAD:  if (!prog_active_i) state <= RUN;
                default: state <= RUN;
            endcase
`ifdef ICCM_ARB_RR_EN
            if (state == RUN && core_req_i && prog_we_i)
                last_prog <= prog_win;
`endif
        end
    end

endmodule
